// File: rtl/rr_decode_arbiter_pkg.sv
// Shared constants for the round-robin decode arbiter: owner-state encoding
// and the width of the tenure hold counter.
package rr_decode_arbiter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam int HOLD_W = 8;

endpackage

// File: rtl/decParamEnable.sv
// n-to-2**n enable decoder: drives the single output bit selected by 'in'
// while 'enable' is high, all zeros otherwise.
module decParamEnable #(
  parameter int n = 2
) (
  input  logic [n-1:0]      in,
  input  logic              enable,
  output logic [(1<<n)-1:0] out
);

  always_comb begin
    out = '0;
    if (enable) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 2**N requesters with tenure hold, explicit release
// and optional MAX_HOLD timeout; the one-hot grant is decoded from registered owner state.
module rr_decode_arbiter
  import rr_decode_arbiter_pkg::*;
#(
  parameter int N        = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [(1<<N)-1:0] req,
  // 'release' is a reserved word, so the owner's release strobe is named owner_release.
  input  logic              owner_release,
  output logic [(1<<N)-1:0] grant,
  output logic              grant_valid,
  output logic [N-1:0]      grant_idx,
  output logic              timeout
);

  localparam int NR = 1 << N;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [N-1:0] ONE = N'(1);

  // Handshake: req[i] is a level; a requester keeps it high for the whole
  // tenure it wants, and the owner may end early with a one-cycle owner_release.
  logic                busy, busy_n;
  logic [N-1:0]        owner, owner_n;
  logic [N-1:0]        ptr, ptr_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic                timeout_n;
  logic                owner_gone;
  logic                hold_exp;
  logic [NR-1:0]       pending;
  logic [N-1:0]        owner_inc;

  // First asserted request at or above p, wrapping modulo NR.
  function automatic logic [N-1:0] pick(input logic [N-1:0] p, input logic [NR-1:0] r);
    logic [N-1:0] idx;
    logic         found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < NR; i++) begin
      idx = p + N'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    busy_n     = busy;
    owner_n    = owner;
    ptr_n      = ptr;
    hold_n     = hold_cnt;
    timeout_n  = 1'b0;
    owner_inc  = owner + ONE;
    owner_gone = owner_release | ~req[owner];
    hold_exp   = HOLD_EN && (hold_cnt == HOLD_LAST);
    pending    = req;
    case (busy)
      ST_IDLE: begin
        if (|req) begin
          busy_n  = ST_BUSY;
          owner_n = pick(ptr, req);
          hold_n  = '0;
        end
      end
      ST_BUSY: begin
        if (owner_gone || hold_exp) begin
          ptr_n = owner_inc;
          // A timed-out owner stays eligible; one that let go does not.
          if (owner_gone) pending[owner] = 1'b0;
          else            timeout_n      = 1'b1;
          if (|pending) begin
            owner_n = pick(owner_inc, pending);
            hold_n  = '0;
          end else begin
            busy_n = ST_IDLE;
          end
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: busy_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= ST_IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      busy     <= busy_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      timeout  <= timeout_n;
    end
  end

  decParamEnable #(.n(N)) u_dec (
    .in     (owner),
    .enable (busy),
    .out    (grant)
  );

  assign grant_valid = busy;
  assign grant_idx   = owner;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter (N=2, MAX_HOLD=4): directed literal checks from
// the test plan plus randomized traffic compared every cycle against a model.
module tb_rr_decode_arbiter;

  localparam int N  = 2;
  localparam int NR = 4;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic          rel = 1'b0;
  logic [NR-1:0] grant;
  logic          grant_valid;
  logic [N-1:0]  grant_idx;
  logic          timeout;

  int n_vec  = 0;
  int n_miss = 0;
  bit run_cmp = 1'b0;

  // Model state: who holds the resource, for how many cycles, and where the scan resumes.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_tenure = 0;
  bit m_to = 1'b0;

  rr_decode_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .owner_release (rel),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(int p, logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return p;
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin : model
    logic [NR-1:0] still;
    bit            let_go;
    bit            expired;
    if (rst) begin
      m_busy   <= 1'b0;
      m_owner  <= 0;
      m_ptr    <= 0;
      m_tenure <= 0;
      m_to     <= 1'b0;
    end else if (!m_busy) begin
      m_to <= 1'b0;
      if (req != 0) begin
        m_busy   <= 1'b1;
        m_owner  <= pick(m_ptr, req);
        m_tenure <= 1;
      end
    end else begin
      let_go  = rel || !req[m_owner];
      expired = (MH != 0) && (m_tenure == MH);
      if (let_go || expired) begin
        still = req;
        if (let_go) still[m_owner] = 1'b0;
        m_to  <= !let_go;
        m_ptr <= (m_owner + 1) % NR;
        if (still != 0) begin
          m_owner  <= pick((m_owner + 1) % NR, still);
          m_tenure <= 1;
        end else begin
          m_busy <= 1'b0;
        end
      end else begin
        m_to     <= 1'b0;
        m_tenure <= m_tenure + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("grant", int'(grant), m_busy ? (1 << m_owner) : 0);
      check("grant_valid", int'(grant_valid), int'(m_busy));
      check("grant_idx", int'(grant_idx), m_owner);
      check("timeout", int'(timeout), int'(m_to));
    end
  end

  int rot_exp[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // Reset with all requesting
    rst = 1'b1; req = 4'b1111; rel = 1'b0;
    tick();
    run_cmp = 1'b1;
    tick();
    check("rst_grant", int'(grant), 0);
    check("rst_valid", int'(grant_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 1'b0;
    tick();
    check("first_grant", int'(grant), 4'b0001);

    // Rotation, release every 2nd cycle, no gaps
    for (int k = 0; k < 4; k++) begin
      rel = 1'b1;
      tick();
      check("rot_grant", int'(grant), rot_exp[k]);
      rel = 1'b0;
      tick();
      check("rot_hold", int'(grant), rot_exp[k]);
    end

    // Reach owner 2, then release with req=0011 -> wraps to 0
    rel = 1'b1;
    tick();
    tick();
    check("owner2", int'(grant), 4'b0100);
    req = 4'b0011;
    tick();
    check("wrap_pick", int'(grant), 4'b0001);
    rel = 1'b0;

    // Owner drop
    req = 4'b0010;
    tick();
    check("drop_setup", int'(grant), 4'b0010);
    req = 4'b0000;
    tick();
    check("drop_idle", int'(grant), 0);
    req = 4'b1111;
    tick();
    check("drop_ptr", int'(grant), 4'b0100);

    // Timeout with req=0101
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("to_hold", int'(grant), 4'b0001);
      check("to_quiet", int'(timeout), 0);
    end
    tick();
    check("to_grant", int'(grant), 4'b0100);
    check("to_pulse", int'(timeout), 1);
    tick();
    check("to_once", int'(timeout), 0);
    check("to_keep", int'(grant), 4'b0100);

    // Mid-tenure reset
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1000;
    tick();
    check("mid_setup", int'(grant), 4'b1000);
    rst = 1'b1; req = 4'b1111;
    tick();
    check("mid_rst", int'(grant), 0);
    rst = 1'b0;
    tick();
    check("mid_rearb", int'(grant), 4'b0001);

    // Single requester: release idles a cycle
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b0100;
    tick();
    rel = 1'b1;
    tick();
    check("single_rel", int'(grant_valid), 0);
    rel = 1'b0;
    tick();
    check("single_back", int'(grant), 4'b0100);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) < 3) req = NR'($urandom_range(0, NR - 1 + 12));
      rel = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b1; req = '0; rel = 1'b0;
    tick();
    @(negedge clk);
    run_cmp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one resource among 2**N requesters and drives a one-hot grant bus.
- Registers the winning index and owner state. The one-hot bus is produced by feeding that index and the busy flag into an n-to-2**n enable decoder.
- Sits between requester blocks and any shared datapath resource (bus, memory port, ALU) that needs exactly one selected client at a time.
- Adds tenure hold, explicit release, and an optional maximum-hold timeout.

Parameters:
- N, 2, index width; the number of requesters is 2**N.
- MAX_HOLD, 16, maximum grant tenure in cycles; 0 disables the timeout. The hold counter is 8 bits wide, so MAX_HOLD is at most 255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  2**N  per-requester request, level-sensitive.
- release  input  1  the current owner ends its tenure; ignored when not busy.
- grant  output  2**N  one-hot grant; all zeros when idle.
- grant_valid  output  1  high while a grant is held (busy).
- grant_idx  output  N  binary index of the current owner; holds its last value when idle.
- timeout  output  1  one-cycle pulse when a tenure is forcibly ended by MAX_HOLD.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: busy=0, owner=0, ptr=0, hold_cnt=0, timeout=0, so grant=0, grant_valid=0, grant_idx=0. Reset asserted mid-tenure drops grant on the next edge; no release handshake is required.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, owner fixed.
- Winner selection: the first asserted req scanning upward from ptr, with wrap-around modulo 2**N. Function is pick(ptr, req).
- IDLE to BUSY: if |req, then owner<=pick(ptr,req), busy<=1, hold_cnt<=0. Grant appears the cycle after req is sampled (latency 1).
- End of tenure (in BUSY): occurs when any of these is true:
  - release=1;
  - req[owner]=0;
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- On end of tenure:
  - ptr<=owner+1, wrapping.
  - Let R = req with the owner bit masked off if that owner released or dropped its request.
  - If |R: owner<=pick(owner+1,R) and stay BUSY with hold_cnt<=0. This is back-to-back, with no dead cycle.
  - Otherwise: busy<=0 and go to IDLE.
- Timeout: on a timeout end, timeout<=1 for exactly one cycle. The owner's req is NOT masked, so a timed-out owner regains the grant only if no other requester is pending.
- Hold counter: when none of the end conditions holds, hold_cnt increments each BUSY cycle.
- Simultaneous events:
  - release plus owner-req drop in the same cycle is a single end.
  - release plus timeout in the same cycle: the release takes precedence, so timeout=0 and the owner is masked.
- Single requester: re-grants itself back-to-back only on timeout. On release it goes IDLE for one cycle.
- Grant output: grant = decode(owner) when busy=1, else all zeros. It is always one-hot or zero and is derived only from registered state.
- Fairness: with all requesters continuously asserting and releasing after 1 cycle, the grant sequence is 0,1,2,3,0,... for N=2.

Decomposition:
- Shared package: the state encoding constants (IDLE=1'b0, BUSY=1'b1) and the hold-counter width constant.
- One sub-module: the existing decParamEnable n-to-2**n enable decoder, instantiated with parameter n=N, in=owner, enable=busy, driving grant.
- The pick function is internal combinational logic, not a separate module.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111. Required: grant=0, grant_valid=0, timeout=0. After rst falls, grant=4'b0001 one cycle later.
- Rotation: req=4'b1111 held, release pulsed every 2nd cycle. Required: grant sequence 0001,0010,0100,1000,0001, no idle gaps.
- Wrap-around pick: owner=2 releases with req=4'b0011. Required: next grant=4'b0001 (index 0, not 1).
- Timeout: MAX_HOLD=4, req=4'b0101, no release. Required: index 0 held 4 cycles, timeout pulses once, then grant=4'b0100.
- Owner drop: req=4'b0010 granted, then req goes to 0. Required: grant=0 next cycle and ptr=2, so a later req=4'b1111 yields grant=4'b0100.
- Mid-tenure reset: while BUSY with grant=4'b1000, assert rst. Required: grant=0 on the next edge, then re-arbitration starts from index 0.
